// File: rtl/commit_rob_if.sv
// Dispatch, writeback and commit signal bundle for the 16-entry dual-issue reorder buffer.
// The ROB itself binds to the slave modport; the issuing pipeline drives through master.
interface commit_rob_if;
    logic        flush;
    logic        disp_valid0;
    logic        disp_valid1;
    logic        disp_rf_wen0;
    logic        disp_rf_wen1;
    logic [4:0]  disp_rd0;
    logic [4:0]  disp_rd1;
    logic [31:0] disp_pc0;
    logic [31:0] disp_pc1;
    logic        disp_ready;
    logic [3:0]  disp_idx0;
    logic [3:0]  disp_idx1;
    logic        wb_valid0;
    logic        wb_valid1;
    logic [3:0]  wb_idx0;
    logic [3:0]  wb_idx1;
    logic [31:0] wb_data0;
    logic [31:0] wb_data1;
    logic        cmt_valid0;
    logic        cmt_valid1;
    logic        rf_wen_0;
    logic        rf_wen_1;
    logic [4:0]  debug0_wb_rf_wnum;
    logic [4:0]  debug1_wb_rf_wnum;
    logic [31:0] debug0_wb_rf_wdata;
    logic [31:0] debug1_wb_rf_wdata;
    logic [31:0] debug0_wb_pc;
    logic [31:0] debug1_wb_pc;

    modport slave (
        input  flush, disp_valid0, disp_valid1, disp_rf_wen0, disp_rf_wen1,
               disp_rd0, disp_rd1, disp_pc0, disp_pc1,
               wb_valid0, wb_valid1, wb_idx0, wb_idx1, wb_data0, wb_data1,
        output disp_ready, disp_idx0, disp_idx1, cmt_valid0, cmt_valid1,
               rf_wen_0, rf_wen_1, debug0_wb_rf_wnum, debug1_wb_rf_wnum,
               debug0_wb_rf_wdata, debug1_wb_rf_wdata, debug0_wb_pc, debug1_wb_pc
    );

    modport master (
        output flush, disp_valid0, disp_valid1, disp_rf_wen0, disp_rf_wen1,
               disp_rd0, disp_rd1, disp_pc0, disp_pc1,
               wb_valid0, wb_valid1, wb_idx0, wb_idx1, wb_data0, wb_data1,
        input  disp_ready, disp_idx0, disp_idx1, cmt_valid0, cmt_valid1,
               rf_wen_0, rf_wen_1, debug0_wb_rf_wnum, debug1_wb_rf_wnum,
               debug0_wb_rf_wdata, debug1_wb_rf_wdata, debug0_wb_pc, debug1_wb_pc
    );
endinterface

// File: rtl/commit_rob.sv
// 16-entry reorder buffer: two-wide in-order dispatch, two writeback ports,
// two-wide in-order commit with registered commit outputs (1-cycle latency).
module commit_rob (
    input  logic         aclk,
    input  logic         reset,
    commit_rob_if.slave  rob
);
    logic [15:0] valid_r;
    logic [15:0] done_r;
    logic [15:0] rfw_r;
    logic [4:0]  rd_r   [0:15];
    logic [31:0] pc_r   [0:15];
    logic [31:0] data_r [0:15];

    logic [3:0]  head_r;
    logic [3:0]  tail_r;
    logic [4:0]  count_r;

    logic        cmt_valid0_r;
    logic        cmt_valid1_r;
    logic        rf_wen0_r;
    logic        rf_wen1_r;
    logic [4:0]  wnum0_r;
    logic [4:0]  wnum1_r;
    logic [31:0] wdata0_r;
    logic [31:0] wdata1_r;
    logic [31:0] wpc0_r;
    logic [31:0] wpc1_r;

    logic        disp_ready_s;
    logic        acc0_s;
    logic        acc1_s;
    logic        cmt0_s;
    logic        cmt1_s;
    logic [3:0]  head1_s;
    logic [3:0]  tail1_s;
    logic [1:0]  acc_n_s;
    logic [1:0]  cmt_n_s;

    function automatic logic [3:0] ptr_add(input logic [3:0] p, input logic [1:0] n);
        return p + {2'b00, n};
    endfunction

    // Dispatch acceptance and commit selection from the registered state only
    always_comb begin
        disp_ready_s = 1'b0;
        acc0_s       = 1'b0;
        acc1_s       = 1'b0;
        cmt0_s       = 1'b0;
        cmt1_s       = 1'b0;
        head1_s      = ptr_add(head_r, 2'd1);
        tail1_s      = ptr_add(tail_r, 2'd1);
        if (count_r <= 5'd14) begin
            disp_ready_s = 1'b1;
        end else begin
            disp_ready_s = 1'b0;
        end
        acc0_s  = rob.disp_valid0 & disp_ready_s;
        acc1_s  = acc0_s & rob.disp_valid1;
        cmt0_s  = valid_r[head_r] & done_r[head_r];
        cmt1_s  = cmt0_s & valid_r[head1_s] & done_r[head1_s];
        acc_n_s = {1'b0, acc0_s} + {1'b0, acc1_s};
        cmt_n_s = {1'b0, cmt0_s} + {1'b0, cmt1_s};
    end

    // Occupancy: valid bits, pointers and count; flush and reset empty the buffer
    always_ff @(posedge aclk) begin
        if (reset || rob.flush) begin
            valid_r <= 16'h0000;
            head_r  <= 4'd0;
            tail_r  <= 4'd0;
            count_r <= 5'd0;
        end else begin
            if (acc0_s) valid_r[tail_r]  <= 1'b1;
            if (acc1_s) valid_r[tail1_s] <= 1'b1;
            // dispatch slots are always free entries, so they never alias a committing head
            if (cmt0_s) valid_r[head_r]  <= 1'b0;
            if (cmt1_s) valid_r[head1_s] <= 1'b0;
            head_r  <= ptr_add(head_r, cmt_n_s);
            tail_r  <= ptr_add(tail_r, acc_n_s);
            count_r <= count_r + {3'b000, acc_n_s} - {3'b000, cmt_n_s};
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge aclk) begin
        if (rob.wb_valid0 && valid_r[rob.wb_idx0]) begin
            done_r[rob.wb_idx0] <= 1'b1;
            data_r[rob.wb_idx0] <= rob.wb_data0;
        end
        // later assignment makes port 1 win on a shared index
        if (rob.wb_valid1 && valid_r[rob.wb_idx1]) begin
            done_r[rob.wb_idx1] <= 1'b1;
            data_r[rob.wb_idx1] <= rob.wb_data1;
        end
        if (acc0_s) begin
            done_r[tail_r] <= 1'b0;
            rfw_r[tail_r]  <= rob.disp_rf_wen0;
            rd_r[tail_r]   <= rob.disp_rd0;
            pc_r[tail_r]   <= rob.disp_pc0;
        end
        if (acc1_s) begin
            done_r[tail1_s] <= 1'b0;
            rfw_r[tail1_s]  <= rob.disp_rf_wen1;
            rd_r[tail1_s]   <= rob.disp_rd1;
            pc_r[tail1_s]   <= rob.disp_pc1;
        end
    end

    // Registered commit outputs; debug fields hold their last committed values
    always_ff @(posedge aclk) begin
        if (reset) begin
            cmt_valid0_r <= 1'b0;
            cmt_valid1_r <= 1'b0;
            rf_wen0_r    <= 1'b0;
            rf_wen1_r    <= 1'b0;
            wnum0_r      <= 5'd0;
            wnum1_r      <= 5'd0;
            wdata0_r     <= 32'h0000_0000;
            wdata1_r     <= 32'h0000_0000;
            wpc0_r       <= 32'h0000_0000;
            wpc1_r       <= 32'h0000_0000;
        end else if (rob.flush) begin
            cmt_valid0_r <= 1'b0;
            cmt_valid1_r <= 1'b0;
            rf_wen0_r    <= 1'b0;
            rf_wen1_r    <= 1'b0;
        end else begin
            cmt_valid0_r <= cmt0_s;
            cmt_valid1_r <= cmt1_s;
            rf_wen0_r    <= cmt0_s & rfw_r[head_r];
            rf_wen1_r    <= cmt1_s & rfw_r[head1_s];
            if (cmt0_s) begin
                wnum0_r  <= rd_r[head_r];
                wdata0_r <= data_r[head_r];
                wpc0_r   <= pc_r[head_r];
            end
            if (cmt1_s) begin
                wnum1_r  <= rd_r[head1_s];
                wdata1_r <= data_r[head1_s];
                wpc1_r   <= pc_r[head1_s];
            end
        end
    end

    assign rob.disp_ready         = disp_ready_s;
    assign rob.disp_idx0          = tail_r;
    assign rob.disp_idx1          = tail1_s;
    assign rob.cmt_valid0         = cmt_valid0_r;
    assign rob.cmt_valid1         = cmt_valid1_r;
    assign rob.rf_wen_0           = rf_wen0_r;
    assign rob.rf_wen_1           = rf_wen1_r;
    assign rob.debug0_wb_rf_wnum  = wnum0_r;
    assign rob.debug1_wb_rf_wnum  = wnum1_r;
    assign rob.debug0_wb_rf_wdata = wdata0_r;
    assign rob.debug1_wb_rf_wdata = wdata1_r;
    assign rob.debug0_wb_pc       = wpc0_r;
    assign rob.debug1_wb_pc       = wpc1_r;
endmodule

// File: tb/tb_commit_rob.sv
// Self-checking bench for commit_rob: directed scenarios plus randomized traffic,
// all compared against an in-order queue model of the reorder buffer.
module tb_commit_rob;
    logic aclk = 1'b0;
    logic reset;
    always #5 aclk = ~aclk;

    commit_rob_if bus ();
    commit_rob dut (.aclk(aclk), .reset(reset), .rob(bus.slave));

    typedef struct {
        logic [3:0]  idx;
        logic        rfw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_tail;
    logic        e_cv0, e_cv1, e_rw0, e_rw1;
    logic [4:0]  e_wn0, e_wn1;
    logic [31:0] e_wd0, e_wd1, e_pc0, e_pc1;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.disp_valid0 = 1'b0;  bus.disp_valid1 = 1'b0;
        bus.wb_valid0 = 1'b0;    bus.wb_valid1 = 1'b0;
    endtask

    task automatic set_disp(input logic v0, input logic v1, input logic [4:0] rd0, input logic [4:0] rd1,
                            input logic [31:0] pc0, input logic [31:0] pc1);
        bus.disp_valid0 = v0;  bus.disp_valid1 = v1;
        bus.disp_rf_wen0 = 1'b1; bus.disp_rf_wen1 = 1'b1;
        bus.disp_rd0 = rd0;    bus.disp_rd1 = rd1;
        bus.disp_pc0 = pc0;    bus.disp_pc1 = pc1;
    endtask

    task automatic set_wb(input logic v0, input logic [3:0] i0, input logic [31:0] d0,
                          input logic v1, input logic [3:0] i1, input logic [31:0] d1);
        bus.wb_valid0 = v0; bus.wb_idx0 = i0; bus.wb_data0 = d0;
        bus.wb_valid1 = v1; bus.wb_idx1 = i1; bus.wb_data1 = d1;
    endtask

    // Apply the current inputs to the model, clock the DUT once, compare everything.
    task automatic step();
        int         sz0;
        bit         c0, c1;
        ent_t       t;
        logic [3:0] t1;
        sz0 = q.size();
        if (reset) begin
            q.delete(); m_tail = 4'd0;
            e_cv0 = 1'b0; e_cv1 = 1'b0; e_rw0 = 1'b0; e_rw1 = 1'b0;
            e_wn0 = 5'd0; e_wn1 = 5'd0; e_wd0 = 32'h0; e_wd1 = 32'h0; e_pc0 = 32'h0; e_pc1 = 32'h0;
        end else if (bus.flush) begin
            q.delete(); m_tail = 4'd0;
            e_cv0 = 1'b0; e_cv1 = 1'b0; e_rw0 = 1'b0; e_rw1 = 1'b0;
        end else begin
            c0 = (sz0 > 0) && q[0].done;
            c1 = c0 && (sz0 > 1) && q[1].done;
            e_cv0 = c0; e_cv1 = c1;
            e_rw0 = c0 && q[0].rfw;
            e_rw1 = c1 && q[1].rfw;
            if (c0) begin e_wn0 = q[0].rd; e_wd0 = q[0].data; e_pc0 = q[0].pc; end
            if (c1) begin e_wn1 = q[1].rd; e_wd1 = q[1].data; e_pc1 = q[1].pc; end
            for (int k = 0; k < q.size(); k++) begin
                t = q[k];
                if (bus.wb_valid0 && t.idx == bus.wb_idx0) begin t.done = 1'b1; t.data = bus.wb_data0; end
                if (bus.wb_valid1 && t.idx == bus.wb_idx1) begin t.done = 1'b1; t.data = bus.wb_data1; end
                q[k] = t;
            end
            if (c0) void'(q.pop_front());
            if (c1) void'(q.pop_front());
            if (bus.disp_valid0 && sz0 <= 14) begin
                t.idx = m_tail; t.rfw = bus.disp_rf_wen0; t.rd = bus.disp_rd0; t.pc = bus.disp_pc0;
                t.done = 1'b0; t.data = 32'h0;
                q.push_back(t);
                m_tail = m_tail + 4'd1;
                if (bus.disp_valid1) begin
                    t.idx = m_tail; t.rfw = bus.disp_rf_wen1; t.rd = bus.disp_rd1; t.pc = bus.disp_pc1;
                    q.push_back(t);
                    m_tail = m_tail + 4'd1;
                end
            end
        end
        @(posedge aclk);
        #1;
        t1 = m_tail + 4'd1;
        check_eq("cmt_valid0", bus.cmt_valid0, e_cv0);
        check_eq("cmt_valid1", bus.cmt_valid1, e_cv1);
        check_eq("rf_wen_0", bus.rf_wen_0, e_rw0);
        check_eq("rf_wen_1", bus.rf_wen_1, e_rw1);
        check_eq("wnum0", bus.debug0_wb_rf_wnum, e_wn0);
        check_eq("wnum1", bus.debug1_wb_rf_wnum, e_wn1);
        check_eq("wdata0", bus.debug0_wb_rf_wdata, e_wd0);
        check_eq("wdata1", bus.debug1_wb_rf_wdata, e_wd1);
        check_eq("pc0", bus.debug0_wb_pc, e_pc0);
        check_eq("pc1", bus.debug1_wb_pc, e_pc1);
        check_eq("disp_ready", bus.disp_ready, (q.size() <= 14) ? 32'd1 : 32'd0);
        check_eq("disp_idx0", bus.disp_idx0, m_tail);
        check_eq("disp_idx1", bus.disp_idx1, t1);
    endtask

    initial begin
        logic [3:0] ri0, ri1;
        q.delete(); m_tail = 4'd0;
        clr_in();
        set_disp(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        set_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        reset = 1'b1;
        step(); step();
        check_eq("rst_ready", bus.disp_ready, 32'd1);
        check_eq("rst_idx1", bus.disp_idx1, 32'd1);
        clr_in();

        // paired dispatch, both complete together, both commit together
        set_disp(1'b1, 1'b1, 5'd3, 5'd4, 32'h1c00_0000, 32'h1c00_0004);
        step(); clr_in();
        set_wb(1'b1, 4'd0, 32'h0000_000A, 1'b1, 4'd1, 32'h0000_000B);
        step(); clr_in(); step();
        check_eq("pair_cv0", bus.cmt_valid0, 32'd1);
        check_eq("pair_cv1", bus.cmt_valid1, 32'd1);
        check_eq("pair_rfw0", bus.rf_wen_0, 32'd1);
        check_eq("pair_wn0", bus.debug0_wb_rf_wnum, 32'd3);
        check_eq("pair_wd0", bus.debug0_wb_rf_wdata, 32'h0000_000A);
        check_eq("pair_wn1", bus.debug1_wb_rf_wnum, 32'd4);
        check_eq("pair_wd1", bus.debug1_wb_rf_wdata, 32'h0000_000B);
        check_eq("pair_pc1", bus.debug1_wb_pc, 32'h1c00_0004);

        // younger completes first: nothing commits until the older one is done
        set_disp(1'b1, 1'b1, 5'd7, 5'd8, 32'h100, 32'h104);
        step(); clr_in();
        set_wb(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0);
        step(); clr_in(); step(); step();
        check_eq("ooo_hold", bus.cmt_valid0, 32'd0);
        set_wb(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h22);
        step(); clr_in(); step();
        check_eq("ooo_cv0", bus.cmt_valid0, 32'd1);
        check_eq("ooo_cv1", bus.cmt_valid1, 32'd1);

        // fill to 15 entries, then free one slot
        bus.flush = 1'b1; step(); clr_in();
        for (int i = 0; i < 7; i++) begin
            set_disp(1'b1, 1'b1, 5'(i), 5'(i + 16), 32'(i * 8), 32'(i * 8 + 4));
            step();
        end
        set_disp(1'b1, 1'b0, 5'd30, 5'd0, 32'h200, 32'h0);
        step(); clr_in();
        check_eq("full_ready", bus.disp_ready, 32'd0);
        set_wb(1'b1, 4'd0, 32'h77, 1'b0, 4'd0, 32'h0);
        step(); clr_in(); step();
        check_eq("free_ready", bus.disp_ready, 32'd1);

        // streaming single dispatches that wrap the tail
        bus.flush = 1'b1; step(); clr_in();
        for (int i = 0; i < 24; i++) begin
            set_disp(1'b1, 1'b0, 5'(i), 5'd0, 32'h1000 + 32'(i * 4), 32'h0);
            if (q.size() > 0) set_wb(1'b1, q[0].idx, $urandom, 1'b0, 4'd0, 32'h0);
            else set_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
            step();
        end
        clr_in();
        for (int i = 0; i < 4; i++) begin
            if (q.size() > 0) set_wb(1'b1, q[0].idx, $urandom, 1'b0, 4'd0, 32'h0);
            step(); clr_in();
        end

        // both writeback ports on index 5: port 1 data must be the committed one
        bus.flush = 1'b1; step(); clr_in();
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 1'b1, 5'(2 * i), 5'(2 * i + 1), 32'(i * 8), 32'(i * 8 + 4));
            step();
        end
        clr_in();
        set_wb(1'b1, 4'd5, 32'd1, 1'b1, 4'd5, 32'd2); step(); clr_in();
        set_wb(1'b1, 4'd0, 32'h10, 1'b1, 4'd1, 32'h11); step(); clr_in();
        set_wb(1'b1, 4'd2, 32'h12, 1'b1, 4'd3, 32'h13); step(); clr_in();
        set_wb(1'b1, 4'd4, 32'h14, 1'b0, 4'd0, 32'h0);  step(); clr_in();
        for (int i = 0; i < 4; i++) step();
        check_eq("wb_conflict", bus.debug1_wb_rf_wdata, 32'd2);

        // flush with a commit-ready head and a same-cycle dispatch
        bus.flush = 1'b1; step(); clr_in();
        set_disp(1'b1, 1'b0, 5'd9, 5'd0, 32'h300, 32'h0); step(); clr_in();
        set_wb(1'b1, 4'd0, 32'h99, 1'b0, 4'd0, 32'h0);    step(); clr_in();
        bus.flush = 1'b1;
        set_disp(1'b1, 1'b0, 5'd10, 5'd0, 32'h304, 32'h0);
        step(); clr_in();
        check_eq("flush_cv0", bus.cmt_valid0, 32'd0);
        check_eq("flush_idx0", bus.disp_idx0, 32'd0);
        check_eq("flush_ready", bus.disp_ready, 32'd1);

        // randomized traffic with occasional flush and mid-stream reset
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            bus.flush = ($urandom_range(0, 59) == 0);
            bus.disp_valid0  = ($urandom_range(0, 9) < 6);
            bus.disp_valid1  = $urandom_range(0, 1) == 1;
            bus.disp_rf_wen0 = $urandom_range(0, 1) == 1;
            bus.disp_rf_wen1 = $urandom_range(0, 1) == 1;
            bus.disp_rd0 = 5'($urandom);  bus.disp_rd1 = 5'($urandom);
            bus.disp_pc0 = $urandom;      bus.disp_pc1 = $urandom;
            ri0 = 4'($urandom);           ri1 = 4'($urandom);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) ri0 = q[$urandom_range(0, q.size() - 1)].idx;
            if (q.size() > 0 && $urandom_range(0, 3) != 0) ri1 = q[$urandom_range(0, q.size() - 1)].idx;
            set_wb($urandom_range(0, 1) == 1, ri0, $urandom, $urandom_range(0, 1) == 1, ri1, $urandom);
            step();
        end
        clr_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/commit_rob.md
COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 SHALL have no parameters; depth is fixed at 16 entries with 4-bit indices.
REQ-002 aclk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  synchronous pipeline flush; discards all entries.
REQ-005 disp_valid0/disp_valid1  in  1 each  dispatch request, slot 0 / slot 1.
REQ-006 disp_rf_wen0/disp_rf_wen1  in  1 each  instruction writes a logical register.
REQ-007 disp_rd0/disp_rd1  in  5 each  destination logical register number.
REQ-008 disp_pc0/disp_pc1  in  32 each  instruction PC.
REQ-009 disp_ready  out  1  both dispatch slots can be accepted this cycle.
REQ-010 disp_idx0/disp_idx1  out  4 each  ROB index assigned to slot 0 / slot 1.
REQ-011 wb_valid0/wb_valid1  in  1 each  execution writeback, port 0 / port 1.
REQ-012 wb_idx0/wb_idx1  in  4 each  ROB index being completed.
REQ-013 wb_data0/wb_data1  in  32 each  result value.
REQ-014 cmt_valid0/cmt_valid1  out  1 each  registered commit strobe, slot 0 / slot 1.
REQ-015 rf_wen_0/rf_wen_1  out  1 each  committed instruction writes the logical register file.
REQ-016 debug0_wb_rf_wnum/debug1_wb_rf_wnum  out  5 each  committed destination register.
REQ-017 debug0_wb_rf_wdata/debug1_wb_rf_wdata  out  32 each  committed result.
REQ-018 debug0_wb_pc/debug1_wb_pc  out  32 each  committed PC.

Function
REQ-019 SHALL keep a 4-bit head pointer, a 4-bit tail pointer and a 5-bit count (0..16); pointers SHALL wrap 15->0.
REQ-020 Each entry SHALL hold valid, done, rf_wen, rd[4:0], pc[31:0] and data[31:0].
REQ-021 disp_ready SHALL be combinational and equal (registered count <= 14); same-cycle commits SHALL NOT be credited.
REQ-022 disp_idx0 SHALL equal tail, and disp_idx1 SHALL equal tail+1 (mod 16).
REQ-023 Slot 0 SHALL be accepted when disp_valid0 & disp_ready; slot 1 SHALL be accepted only when slot 0 is also accepted, and disp_valid1 without disp_valid0 SHALL be ignored.
REQ-024 Accepted entries SHALL be written with valid=1 and done=0, and tail SHALL advance by the number accepted (0, 1 or 2).
REQ-025 A writeback SHALL set done=1 and data=wb_data only when the target entry is valid; writebacks to invalid entries SHALL be dropped.
REQ-026 When both writeback ports target the same index, port 1 SHALL win.
REQ-027 Commit decision, cycle t: slot 0 SHALL commit if entry[head] is valid&done; slot 1 SHALL commit if slot 0 commits and entry[head+1] is valid&done.
REQ-028 Committed entries SHALL be invalidated, and head SHALL advance by the commit count at the edge ending cycle t.
REQ-029 cmt_valid*, rf_wen_* (= entry rf_wen & commit), wnum, wdata and pc SHALL be registered and SHALL appear in cycle t+1, giving 1-cycle commit latency.
REQ-030 With no commit, cmt_valid* and rf_wen_* SHALL be 0; wnum, wdata and pc SHALL hold their last values.
REQ-031 A writeback in cycle t SHALL make the entry commit-eligible no earlier than cycle t+1, so cmt_valid rises no earlier than t+2.
REQ-032 count SHALL update as count + accepted - committed; count SHALL never exceed 16 or go below 0.
REQ-033 Simultaneous dispatch and commit SHALL both take effect in the same cycle.
REQ-034 flush SHALL have priority over dispatch, writeback and commit: all valid bits cleared, head=tail=count=0, and cmt_valid*/rf_wen_*=0 next cycle.

Reset
REQ-035 reset SHALL act as flush and additionally clear wnum, wdata and pc outputs to 0.
REQ-036 After reset, all outputs SHALL be 0 except disp_ready=1, disp_idx0=0 and disp_idx1=1.
REQ-037 reset asserted mid-operation SHALL discard all in-flight entries without emitting any commit.

Verification
REQ-038 Dispatch rd=3/pc=0x1c000000 and rd=4/pc=0x1c000004, then writeback idx1=0xB and idx0=0xA in the same cycle -> next cycle both commit together: rf_wen_0=1, wnum=3, wdata=0xA, then slot 1 wnum=4, wdata=0xB.
REQ-039 Complete idx1 only -> no commit; complete idx0 later -> both commit in the same cycle.
REQ-040 Dispatch pairs until count=15 -> disp_ready=0; one commit -> count=14 -> disp_ready=1.
REQ-041 Cycle 24 dispatches with interleaved commits so tail wraps 15->0 -> indices continue 14,15,0,1 and commit order is preserved.
REQ-042 Both wb ports target idx 5 with data 1 and 2 -> committed wdata=2.
REQ-043 flush asserted while head is done, with a same-cycle dispatch -> no cmt_valid next cycle, count=0, disp_idx0=0.
